pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 156 +++++++++++++++
 tb/tb_pipe_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline register control for the IF, ID and EX stages: PC, IF/ID and ID/EX
// registers with stall/flush handling, plus saturating stall and flush counters.
module pipe_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             StallF,
  input  logic             StallD,
  input  logic             FlushE,
  input  logic             PCSrcD,
  input  logic [31:0]      PCBranchD,
  input  logic [31:0]      InstrF,
  input  logic             RegWriteD,
  input  logic             MemtoRegD,
  input  logic             MemWriteD,
  input  logic             ALUSrcD,
  input  logic             RegDstD,
  input  logic [2:0]       ALUControlD,
  input  logic [4:0]       RsD,
  input  logic [4:0]       RtD,
  input  logic [4:0]       RdD,
  output logic [31:0]      PCF,
  output logic [31:0]      InstrD,
  output logic [31:0]      PCPlus4D,
  output logic             ValidD,
  output logic             ValidE,
  output logic             RegWriteE,
  output logic             MemtoRegE,
  output logic             MemWriteE,
  output logic             ALUSrcE,
  output logic             RegDstE,
  output logic [2:0]       ALUControlE,
  output logic [4:0]       RsE,
  output logic [4:0]       RtE,
  output logic [4:0]       RdE,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  logic [31:0]      r_pc;
  logic [31:0]      r_instr_d;
  logic [31:0]      r_pc_plus4_d;
  logic             r_valid_d;
  logic             r_valid_e;
  logic             r_reg_write_e;
  logic             r_mem_to_reg_e;
  logic             r_mem_write_e;
  logic             r_alu_src_e;
  logic             r_reg_dst_e;
  logic [2:0]       r_alu_ctrl_e;
  logic [4:0]       r_rs_e;
  logic [4:0]       r_rt_e;
  logic [4:0]       r_rd_e;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic [31:0]      w_pc_plus4_f;
  logic             w_branch_taken;
  logic             w_stall_any;
  logic             w_flush_any;

  // A branch resolved while decode is stalled has stale operands, so it is ignored.
  assign w_pc_plus4_f   = r_pc + 32'd4;
  assign w_branch_taken = PCSrcD && !StallD;
  assign w_stall_any    = StallF || StallD;
  assign w_flush_any    = FlushE || w_branch_taken;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc           <= RESET_PC;
      r_instr_d      <= 32'd0;
      r_pc_plus4_d   <= 32'd0;
      r_valid_d      <= 1'b0;
      r_valid_e      <= 1'b0;
      r_reg_write_e  <= 1'b0;
      r_mem_to_reg_e <= 1'b0;
      r_mem_write_e  <= 1'b0;
      r_alu_src_e    <= 1'b0;
      r_reg_dst_e    <= 1'b0;
      r_alu_ctrl_e   <= 3'd0;
      r_rs_e         <= 5'd0;
      r_rt_e         <= 5'd0;
      r_rd_e         <= 5'd0;
      r_stall_cnt    <= '0;
      r_flush_cnt    <= '0;
    end else begin
      if (!StallF) begin
        r_pc <= w_branch_taken ? PCBranchD : w_pc_plus4_f;
      end

      if (!StallD) begin
        if (PCSrcD) begin
          r_instr_d    <= 32'd0;
          r_pc_plus4_d <= 32'd0;
          r_valid_d    <= 1'b0;
        end else begin
          r_instr_d    <= InstrF;
          r_pc_plus4_d <= w_pc_plus4_f;
          r_valid_d    <= 1'b1;
        end
      end

      // ID/EX is never held: either a bubble or a fresh load every cycle.
      if (FlushE) begin
        r_valid_e      <= 1'b0;
        r_reg_write_e  <= 1'b0;
        r_mem_to_reg_e <= 1'b0;
        r_mem_write_e  <= 1'b0;
        r_alu_src_e    <= 1'b0;
        r_reg_dst_e    <= 1'b0;
        r_alu_ctrl_e   <= 3'd0;
        r_rs_e         <= 5'd0;
        r_rt_e         <= 5'd0;
        r_rd_e         <= 5'd0;
      end else begin
        r_valid_e      <= r_valid_d;
        r_reg_write_e  <= RegWriteD;
        r_mem_to_reg_e <= MemtoRegD;
        r_mem_write_e  <= MemWriteD;
        r_alu_src_e    <= ALUSrcD;
        r_reg_dst_e    <= RegDstD;
        r_alu_ctrl_e   <= ALUControlD;
        r_rs_e         <= RsD;
        r_rt_e         <= RtD;
        r_rd_e         <= RdD;
      end

      if (w_stall_any && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_flush_any && (r_flush_cnt != {CNT_W{1'b1}})) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign PCF         = r_pc;
  assign InstrD      = r_instr_d;
  assign PCPlus4D    = r_pc_plus4_d;
  assign ValidD      = r_valid_d;
  assign ValidE      = r_valid_e;
  assign RegWriteE   = r_reg_write_e;
  assign MemtoRegE   = r_mem_to_reg_e;
  assign MemWriteE   = r_mem_write_e;
  assign ALUSrcE     = r_alu_src_e;
  assign RegDstE     = r_reg_dst_e;
  assign ALUControlE = r_alu_ctrl_e;
  assign RsE         = r_rs_e;
  assign RtE         = r_rt_e;
  assign RdE         = r_rd_e;
  assign StallCount  = r_stall_cnt;
  assign FlushCount  = r_flush_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: a reference model feeds a scoreboard queue,
// plus directed checks on the named scenarios.
module tb_pipe_ctrl;

  typedef struct packed {
    logic        reset;
    logic        stall_f;
    logic        stall_d;
    logic        flush_e;
    logic        pc_src_d;
    logic [31:0] pc_branch_d;
    logic [31:0] instr_f;
    logic [22:0] ctrl_d;   // {RegWrite,MemtoReg,MemWrite,ALUSrc,RegDst,ALUControl,Rs,Rt,Rd}
  } stim_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr_d;
    logic [31:0] pc_plus4_d;
    logic        valid_d;
    logic        valid_e;
    logic [22:0] ctrl_e;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        StallF, StallD, FlushE, PCSrcD;
  logic [31:0] PCBranchD, InstrF;
  logic        RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD;
  logic [2:0]  ALUControlD;
  logic [4:0]  RsD, RtD, RdD;
  logic [31:0] PCF, InstrD, PCPlus4D;
  logic        ValidD, ValidE;
  logic        RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE;
  logic [2:0]  ALUControlE;
  logic [4:0]  RsE, RtE, RdE;
  logic [15:0] StallCount, FlushCount;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t m;
  exp_t q[$];

  pipe_ctrl #(.RESET_PC(32'h0000_0000), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .StallF(StallF), .StallD(StallD), .FlushE(FlushE), .PCSrcD(PCSrcD),
    .PCBranchD(PCBranchD), .InstrF(InstrF),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD),
    .ALUSrcD(ALUSrcD), .RegDstD(RegDstD), .ALUControlD(ALUControlD),
    .RsD(RsD), .RtD(RtD), .RdD(RdD),
    .PCF(PCF), .InstrD(InstrD), .PCPlus4D(PCPlus4D),
    .ValidD(ValidD), .ValidE(ValidE),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
    .ALUSrcE(ALUSrcE), .RegDstE(RegDstE), .ALUControlE(ALUControlE),
    .RsE(RsE), .RtE(RtE), .RdE(RdE),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  always #5 clk = ~clk;

  // Reference behaviour of one clock edge.
  function automatic exp_t model_next(input exp_t s, input stim_t i);
    exp_t n;
    logic [31:0] pc4;
    n = s;
    pc4 = s.pc + 32'd4;
    if (i.reset) begin
      n = '0;
      return n;
    end
    if (!i.stall_f) n.pc = (i.pc_src_d && !i.stall_d) ? i.pc_branch_d : pc4;
    if (!i.stall_d) begin
      if (i.pc_src_d) begin
        n.instr_d = 32'd0; n.pc_plus4_d = 32'd0; n.valid_d = 1'b0;
      end else begin
        n.instr_d = i.instr_f; n.pc_plus4_d = pc4; n.valid_d = 1'b1;
      end
    end
    if (i.flush_e) begin
      n.ctrl_e = '0; n.valid_e = 1'b0;
    end else begin
      n.ctrl_e = i.ctrl_d; n.valid_e = s.valid_d;
    end
    if ((i.stall_f || i.stall_d) && s.stall_cnt != 16'hFFFF) n.stall_cnt = s.stall_cnt + 16'd1;
    if ((i.flush_e || (i.pc_src_d && !i.stall_d)) && s.flush_cnt != 16'hFFFF)
      n.flush_cnt = s.flush_cnt + 16'd1;
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Drive one cycle, push the model's prediction, then pop and compare after the edge.
  task automatic step(input stim_t st, input bit do_check);
    exp_t e;
    e = model_next(m, st);
    m = e;
    q.push_back(e);
    reset = st.reset; StallF = st.stall_f; StallD = st.stall_d; FlushE = st.flush_e;
    PCSrcD = st.pc_src_d; PCBranchD = st.pc_branch_d; InstrF = st.instr_f;
    {RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD, ALUControlD, RsD, RtD, RdD} = st.ctrl_d;
    @(posedge clk);
    #1;
    e = q.pop_front();
    if (do_check) begin
      check("sb_pcf",      PCF,      e.pc);
      check("sb_instrd",   InstrD,   e.instr_d);
      check("sb_pcplus4d", PCPlus4D, e.pc_plus4_d);
      check("sb_validd",   32'(ValidD), 32'(e.valid_d));
      check("sb_valide",   32'(ValidE), 32'(e.valid_e));
      check("sb_ctrle", 32'({RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE,
                              ALUControlE, RsE, RtE, RdE}), 32'(e.ctrl_e));
      check("sb_stallcnt", 32'(StallCount), 32'(e.stall_cnt));
      check("sb_flushcnt", 32'(FlushCount), 32'(e.flush_cnt));
    end
  endtask

  function automatic stim_t idle(input logic [31:0] instr);
    stim_t s;
    s = '0;
    s.instr_f = instr;
    s.ctrl_d  = {5'b10010, 3'b010, 5'd1, 5'd2, 5'd3};
    return s;
  endfunction

  initial begin
    stim_t s;
    m = '0;
    s = idle(32'h0);
    reset = 1'b1; StallF = 1'b0; StallD = 1'b0; FlushE = 1'b0; PCSrcD = 1'b0;
    PCBranchD = 32'h0; InstrF = 32'h0;
    {RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD, ALUControlD, RsD, RtD, RdD} = '0;
    #1;

    // Reset with stall/flush asserted: nothing counted.
    s = idle(32'h0); s.reset = 1'b1; s.stall_f = 1'b1; s.flush_e = 1'b1; s.pc_src_d = 1'b1;
    step(s, 1'b1);
    check("rst_pcf", PCF, 32'h0);
    check("rst_cnt", 32'({StallCount, FlushCount}), 32'h0);

    // Three clean cycles.
    step(idle(32'h1111_1111), 1'b1);
    check("run_pcf1", PCF, 32'h4);
    step(idle(32'h1111_1111), 1'b1);
    check("run_pcf2", PCF, 32'h8);
    check("run_instrd", InstrD, 32'h1111_1111);
    check("run_pcplus4d", PCPlus4D, 32'h8);
    step(idle(32'h1111_1111), 1'b1);
    check("run_pcf3", PCF, 32'hC);
    check("run_valide", 32'(ValidE), 32'h1);

    // Stall everything plus bubble at PCF=8.
    s = idle(32'h0); s.reset = 1'b1; step(s, 1'b1);
    step(idle(32'h1111_1111), 1'b1);
    step(idle(32'h1111_1111), 1'b1);
    s = idle(32'h2222_2222); s.stall_f = 1'b1; s.stall_d = 1'b1; s.flush_e = 1'b1;
    step(s, 1'b1);
    check("stl_pcf", PCF, 32'h8);
    check("stl_instrd", InstrD, 32'h1111_1111);
    check("stl_valide", 32'(ValidE), 32'h0);
    check("stl_regwritee", 32'(RegWriteE), 32'h0);
    check("stl_stallcnt", 32'(StallCount), 32'h1);
    check("stl_flushcnt", 32'(FlushCount), 32'h1);

    // Taken branch.
    s = idle(32'h3333_3333); s.pc_src_d = 1'b1; s.pc_branch_d = 32'h40;
    step(s, 1'b1);
    check("br_pcf", PCF, 32'h40);
    check("br_instrd", InstrD, 32'h0);
    check("br_validd", 32'(ValidD), 32'h0);
    check("br_flushcnt", 32'(FlushCount), 32'h2);

    // Branch while decode stalled is ignored.
    step(idle(32'h2222_2222), 1'b1);
    s = idle(32'h4444_4444); s.pc_src_d = 1'b1; s.pc_branch_d = 32'h80;
    s.stall_f = 1'b1; s.stall_d = 1'b1;
    step(s, 1'b1);
    check("brs_pcf", PCF, 32'h44);
    check("brs_instrd", InstrD, 32'h2222_2222);
    check("brs_flushcnt", 32'(FlushCount), 32'h2);

    // Randomised mix against the model.
    for (int k = 0; k < 60; k++) begin
      s.reset       = ($urandom_range(0, 19) == 0);
      s.stall_f     = ($urandom_range(0, 3) == 0);
      s.stall_d     = ($urandom_range(0, 3) == 0);
      s.flush_e     = ($urandom_range(0, 3) == 0);
      s.pc_src_d    = ($urandom_range(0, 4) == 0);
      s.pc_branch_d = $urandom & 32'hFFFF_FFFC;
      s.instr_f     = $urandom;
      s.ctrl_d      = 23'($urandom);
      step(s, 1'b1);
    end

    // PC wrap.
    s = idle(32'h5); s.pc_src_d = 1'b1; s.pc_branch_d = 32'hFFFF_FFFC; step(s, 1'b1);
    step(idle(32'h6), 1'b1);
    check("wrap_pcf", PCF, 32'h0);
    check("wrap_pcplus4d", PCPlus4D, 32'h0);

    // Reset during a stall at PCF=0x20.
    s = idle(32'h7); s.pc_src_d = 1'b1; s.pc_branch_d = 32'h20; step(s, 1'b1);
    check("rs_pre_pcf", PCF, 32'h20);
    s = idle(32'h7); s.stall_f = 1'b1; s.reset = 1'b1; step(s, 1'b1);
    check("rs_pcf", PCF, 32'h0);
    check("rs_cnt", 32'({StallCount, FlushCount}), 32'h0);

    // Stall counter saturation.
    s = idle(32'h8); s.stall_f = 1'b1;
    for (int k = 0; k < 65533; k++) step(s, 1'b0);
    step(s, 1'b1);
    check("sat_fffe", 32'(StallCount), 32'h0000_FFFE);
    step(s, 1'b1);
    check("sat_ffff", 32'(StallCount), 32'h0000_FFFF);
    step(s, 1'b1);
    step(s, 1'b1);
    check("sat_hold", 32'(StallCount), 32'h0000_FFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
